dcache_l2_if: RTL and testbench
===============================

Name: dcache_l2_if

Overview:
- Miss-handling interface downstream of the MEM stage's data-cache controller.
- Consumes drq / l2_cache_rw / l2_addr / data_rd, returns l2_busy / l2_rdy / complete / l2_complete plus the refill line.
- Owns a small victim write-back buffer (wbuf) and a single-outstanding-read L2 port, so dirty evictions do not serialise the refill.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width (16-byte line; line address = addr[ADDR_W-1:4])
- WBUF_DEPTH, 2, victim buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- drq  in  1  dcache request, held until complete (read) or l2_complete (write)
- l2_cache_rw  in  1  1 = victim write, 0 = refill read
- l2_addr  in  ADDR_W  request byte address; low 4 bits ignored
- data_rd  in  LINE_W  victim line, valid with a write drq
- l2_busy  out  1  interface cannot accept a new request
- l2_rdy  out  1  one-cycle pulse; data_wd_l2 valid
- data_wd_l2  out  LINE_W  refill line, registered
- complete  out  1  one-cycle pulse, cycle after l2_rdy
- l2_complete  out  1  one-cycle pulse on victim accept
- l2_req  out  1  L2 port request
- l2_we  out  1  L2 port write
- l2_req_addr  out  ADDR_W-4  L2 line address
- l2_wdata  out  LINE_W  L2 write line
- l2_gnt  in  1  L2 accepts the current request
- l2_rvalid  in  1  L2 read data valid
- l2_rdata  in  LINE_W  L2 read line

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0, wbuf count 0, both FSMs idle; an in-flight read is abandoned and a later l2_rvalid is ignored until the next read is granted.
- Victim write: drq & l2_cache_rw in IDLE with wbuf not full -> enqueue {line addr, data_rd}; l2_complete=1 the next cycle. When full, hold off until a slot frees. There is no same-cycle enqueue on a dequeue from a full buffer.
- Read FSM states: IDLE, RD_REQ, RD_WAIT, FILL, DONE.
  - IDLE -> RD_REQ on drq & !l2_cache_rw once the ordering rule allows it.
  - RD_REQ: l2_req=1, l2_we=0, holding address stable until l2_gnt, then RD_WAIT.
  - RD_WAIT: on l2_rvalid, latch l2_rdata, go to FILL.
  - FILL: l2_rdy=1, go to DONE.
  - DONE: complete=1, go to IDLE.
- Best-case read latency with an empty wbuf and gnt/rvalid same cycle: drq cycle 0, l2_req cycle 1, l2_rdy cycle 3, complete cycle 4.
- Drain engine: when the read FSM is not in RD_REQ/RD_WAIT and wbuf is non-empty, present the head (l2_req=1, l2_we=1); dequeue on l2_gnt. Reads own the port while in RD_REQ/RD_WAIT; a drain already presented keeps the port until gnt.
- Ordering without the optional feature: a read leaves IDLE only when wbuf is empty and no drain is pending.
- l2_busy = (read FSM != IDLE) | wbuf full | (read waiting on drain).
- drq may drop mid-transaction (flush). The transaction still completes and pulses are still issued; dcache_ctrl ignores them.
- A new drq is sampled only in IDLE. The same request level seen in the cycle of complete/l2_complete is not re-accepted; a one-cycle acceptance mask applies.
- wbuf pointers wrap modulo WBUF_DEPTH; count width is clog2(WBUF_DEPTH)+1.

Optional Feature:
- Macro: DCACHE_WBUF_FWD_EN.
- Defined:
  - A read whose line address matches any valid wbuf entry (youngest wins) is served from the buffer: IDLE -> FILL directly, with no L2 access and no wait for the drain.
  - A non-matching read bypasses the buffered writes and goes to L2 immediately.
- Undefined: the strict drain-before-read rule above applies; no address comparators are built.

Decomposition:
- Shared package dcache_pkg:
  - LINE_OFS_W=4 and line-address slicing macro
  - read FSM state encodings (IDLE..DONE)
  - wbuf entry struct {valid, line_addr, data}
- Sub-module dcache_wbuf: FIFO storage, pointers/count, full/empty, plus the associative match port when DCACHE_WBUF_FWD_EN is defined.

Test Plan:
- Refill, empty wbuf: drq read addr 0x0000_1230, gnt at cycle 1, rvalid at cycle 2 with 0xA5..A5 -> l2_req_addr=0x000_0123, l2_rdy cycle 3 with data_wd_l2=0xA5..A5, complete cycle 4.
- Victim then refill: write 0x2000 data D1, then read 0x3000 -> l2_complete one cycle after write drq. Without the feature, the L2 write to 0x200 is granted before the read l2_req asserts.
- wbuf full: 3 writes with l2_gnt held 0 -> first two accepted, third sees l2_busy=1 and is accepted one cycle after the first gnt frees a slot.
- Forwarding (DCACHE_WBUF_FWD_EN): write 0x4000 D2 with l2_gnt=0, then read 0x4008 -> l2_rdy with D2, no read l2_req issued.
- Reset mid-read: reset=0 in RD_WAIT, then rvalid arrives -> l2_rdy/complete remain 0, l2_req=0, wbuf empty.
- Flush: drq dropped in RD_REQ -> read still completes, complete pulses once, no duplicate request issued.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types for the dcache-to-L2 miss interface.
// Line-address slicing, read FSM encodings and victim buffer entry.
`ifndef DCACHE_PKG_SV
`define DCACHE_PKG_SV

`define DCACHE_LINE_ADDR(a) a[$bits(a)-1:dcache_pkg::LINE_OFS_W]

package dcache_pkg;

    localparam int LINE_OFS_W = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;
    localparam int LADDR_W    = DEF_ADDR_W - LINE_OFS_W;

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_FILL = 3'd3,
        RD_DONE = 3'd4
    } rd_state_e;

    typedef struct packed {
        logic                  valid;
        logic [LADDR_W-1:0]    line_addr;
        logic [DEF_LINE_W-1:0] data;
    } wbuf_entry_t;

endpackage

`endif

// File: rtl/dcache_wbuf.sv
// dcache_wbuf: victim write-back FIFO with pointers, count and flags.
// DCACHE_WBUF_FWD_EN adds an associative lookup (youngest match wins).
module dcache_wbuf
    import dcache_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq,
    input  logic [LADDR_W-1:0]    enq_addr,
    input  logic [DEF_LINE_W-1:0] enq_data,
    input  logic                  deq,
    output logic [LADDR_W-1:0]    head_addr,
    output logic [DEF_LINE_W-1:0] head_data,
`ifdef DCACHE_WBUF_FWD_EN
    input  logic [LADDR_W-1:0]    match_addr,
    output logic                  match_hit,
    output logic [DEF_LINE_W-1:0] match_data,
`endif
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t     mem_q [DEPTH];
    wbuf_entry_t     mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            enq_ok, deq_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ok    = enq & ~full;
    assign deq_ok    = deq & ~empty;
    assign head_addr = mem_q[rd_ptr_q].line_addr;
    assign head_data = mem_q[rd_ptr_q].data;

    // Next-state for storage, pointers and occupancy count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_ok) begin
            mem_d[wr_ptr_q].valid     = 1'b1;
            mem_d[wr_ptr_q].line_addr = enq_addr;
            mem_d[wr_ptr_q].data      = enq_data;
            wr_ptr_d                  = wr_ptr_q + 1'b1;
        end
        if (deq_ok) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(enq_ok) - CW'(deq_ok);
    end

    // Storage and pointer registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef DCACHE_WBUF_FWD_EN
    // Scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        match_hit  = 1'b0;
        match_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (mem_q[idx].valid &&
                mem_q[idx].line_addr == match_addr) begin
                match_hit  = 1'b1;
                match_data = mem_q[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/dcache_l2_if.sv
// dcache_l2_if: refill read FSM, victim buffer and shared L2 port.
// Optional DCACHE_WBUF_FWD_EN: reads served from / bypass the wbuf.
module dcache_l2_if
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int WBUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     drq,
    input  logic                     l2_cache_rw,
    input  logic [ADDR_W-1:0]        l2_addr,
    input  logic [LINE_W-1:0]        data_rd,
    output logic                     l2_busy,
    output logic                     l2_rdy,
    output logic [LINE_W-1:0]        data_wd_l2,
    output logic                     complete,
    output logic                     l2_complete,
    output logic                     l2_req,
    output logic                     l2_we,
    output logic [ADDR_W-5:0]        l2_req_addr,
    output logic [LINE_W-1:0]        l2_wdata,
    input  logic                     l2_gnt,
    input  logic                     l2_rvalid,
    input  logic [LINE_W-1:0]        l2_rdata
);

    localparam int LA_W = ADDR_W - LINE_OFS_W;

    rd_state_e           state_q, state_d;
    logic [LA_W-1:0]     rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                l2_complete_q, l2_complete_d;
    logic                drain_hold_q, drain_hold_d;

    logic [LA_W-1:0]     req_line;
    logic                unused_lo;
    logic                in_idle, mask;
    logic                wr_accept, rd_req_ok;
    logic                rd_go, rd_hit, rd_stall;
    logic                drain_req, rd_owns;
    logic                wb_full, wb_empty;
    logic [LA_W-1:0]     wb_head_addr;
    logic [LINE_W-1:0]   wb_head_data;
    logic [LINE_W-1:0]   hit_data;

    assign req_line  = `DCACHE_LINE_ADDR(l2_addr);
    assign unused_lo = ^l2_addr[LINE_OFS_W-1:0];

    assign in_idle   = (state_q == RD_IDLE);
    assign mask      = l2_complete_q | (state_q == RD_DONE);
    assign wr_accept = in_idle & drq & l2_cache_rw & ~wb_full & ~mask;
    assign rd_req_ok = in_idle & drq & ~l2_cache_rw & ~mask;

`ifdef DCACHE_WBUF_FWD_EN
    logic wb_hit;

    assign rd_hit = rd_req_ok & wb_hit;
    assign rd_go  = rd_req_ok & ~wb_hit & ~drain_hold_q;
`else
    assign hit_data = '0;
    assign rd_hit   = 1'b0;
    assign rd_go    = rd_req_ok & wb_empty & ~drain_hold_q;
`endif

    assign rd_stall  = rd_req_ok & ~rd_hit & ~rd_go;
    assign rd_owns   = (state_q == RD_REQ) | (state_q == RD_WAIT);
    assign drain_req = ~wb_empty & ~rd_owns & ~rd_go;

    dcache_wbuf #(
        .DEPTH      (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .enq        (wr_accept),
        .enq_addr   (req_line),
        .enq_data   (data_rd),
        .deq        (drain_req & l2_gnt),
        .head_addr  (wb_head_addr),
        .head_data  (wb_head_data),
`ifdef DCACHE_WBUF_FWD_EN
        .match_addr (req_line),
        .match_hit  (wb_hit),
        .match_data (hit_data),
`endif
        .full       (wb_full),
        .empty      (wb_empty)
    );

    // Read FSM next state, latched address and refill line
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        rdata_d       = rdata_q;
        l2_complete_d = wr_accept;
        drain_hold_d  = drain_req & ~l2_gnt;
        unique case (state_q)
            RD_IDLE: begin
                if (rd_hit) begin
                    state_d   = RD_FILL;
                    rd_addr_d = req_line;
                    rdata_d   = hit_data;
                end else if (rd_go) begin
                    state_d   = RD_REQ;
                    rd_addr_d = req_line;
                end
            end
            RD_REQ: begin
                if (l2_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (l2_rvalid) begin
                    state_d = RD_FILL;
                    rdata_d = l2_rdata;
                end
            end
            RD_FILL: state_d = RD_DONE;
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // L2 port mux: read owns it in REQ/WAIT, else the drain head
    always_comb begin
        l2_req      = 1'b0;
        l2_we       = 1'b0;
        l2_req_addr = rd_addr_q;
        l2_wdata    = wb_head_data;
        if (state_q == RD_REQ) begin
            l2_req = 1'b1;
        end else if (drain_req) begin
            l2_req      = 1'b1;
            l2_we       = 1'b1;
            l2_req_addr = wb_head_addr;
        end
    end

    // FSM state and pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RD_IDLE;
            rd_addr_q     <= '0;
            rdata_q       <= '0;
            l2_complete_q <= 1'b0;
            drain_hold_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            rdata_q       <= rdata_d;
            l2_complete_q <= l2_complete_d;
            drain_hold_q  <= drain_hold_d;
        end
    end

    assign l2_busy     = ~in_idle | wb_full | rd_stall;
    assign l2_rdy      = (state_q == RD_FILL);
    assign complete    = (state_q == RD_DONE);
    assign l2_complete = l2_complete_q;
    assign data_wd_l2  = rdata_q;

endmodule

// File: tb/tb_dcache_l2_if.sv
// tb_dcache_l2_if: directed vector table plus multi-cycle sequences.
// Forwarding sequence only when DCACHE_WBUF_FWD_EN is defined.
module tb_dcache_l2_if;

    logic          clk = 1'b0;
    logic          reset;
    logic          drq, l2_cache_rw;
    logic [31:0]   l2_addr;
    logic [127:0]  data_rd;
    logic          l2_busy, l2_rdy, complete, l2_complete;
    logic [127:0]  data_wd_l2;
    logic          l2_req, l2_we;
    logic [27:0]   l2_req_addr;
    logic [127:0]  l2_wdata;
    logic          l2_gnt, l2_rvalid;
    logic [127:0]  l2_rdata;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] D1 = {4{32'hD1D1_0001}};
    localparam logic [127:0] BB = {4{32'hB0B0_0002}};
    localparam logic [127:0] E1 = {4{32'hE1E1_0011}};
    localparam logic [127:0] E2 = {4{32'hE2E2_0022}};
    localparam logic [127:0] E3 = {4{32'hE3E3_0033}};
    localparam logic [127:0] CC = {4{32'hCCCC_0044}};
    localparam logic [127:0] FF = {4{32'hF0F0_0055}};
    localparam logic [127:0] Z  = '0;

    always #5 clk = ~clk;

    dcache_l2_if dut (
        .clk         (clk),
        .reset       (reset),
        .drq         (drq),
        .l2_cache_rw (l2_cache_rw),
        .l2_addr     (l2_addr),
        .data_rd     (data_rd),
        .l2_busy     (l2_busy),
        .l2_rdy      (l2_rdy),
        .data_wd_l2  (data_wd_l2),
        .complete    (complete),
        .l2_complete (l2_complete),
        .l2_req      (l2_req),
        .l2_we       (l2_we),
        .l2_req_addr (l2_req_addr),
        .l2_wdata    (l2_wdata),
        .l2_gnt      (l2_gnt),
        .l2_rvalid   (l2_rvalid),
        .l2_rdata    (l2_rdata)
    );

    typedef struct {
        logic         drq, rw;
        logic [31:0]  addr;
        logic [127:0] wd;
        logic         gnt, rv;
        logic [127:0] rd;
        logic [5:0]   o;
        logic [27:0]  ra;
        logic [127:0] wdat, dwd;
    } vec_t;

    function automatic vec_t mk(
        input logic d, rw, input logic [31:0] a,
        input logic [127:0] wd, input logic g, rv,
        input logic [127:0] rd, input logic [5:0] o,
        input logic [27:0] ra, input logic [127:0] wdat, dwd);
        vec_t v;
        v.drq = d;  v.rw = rw; v.addr = a; v.wd = wd;
        v.gnt = g;  v.rv = rv; v.rd = rd;  v.o = o;
        v.ra = ra;  v.wdat = wdat; v.dwd = dwd;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {l2_busy, l2_rdy, complete,
                l2_complete, l2_req, l2_we};
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] got, exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic d, rw, input logic [31:0] a,
                         input logic [127:0] wd, input logic g, rv,
                         input logic [127:0] rd);
        drq = d; l2_cache_rw = rw; l2_addr = a; data_rd = wd;
        l2_gnt = g; l2_rvalid = rv; l2_rdata = rd;
    endtask

    vec_t vt [17];
    int   n_cmp, n_rreq;

    initial begin
        // {busy,rdy,cmp,l2c,req,we}
        vt[0]  = mk(1,0,32'h1230,Z,0,0,Z, 6'b000000,28'h0,  Z,Z);
        vt[1]  = mk(1,0,32'h1230,Z,1,0,Z, 6'b100010,28'h123,Z,Z);
        vt[2]  = mk(1,0,32'h1230,Z,0,1,A5,6'b100000,28'h123,Z,Z);
        vt[3]  = mk(1,0,32'h1230,Z,0,0,Z, 6'b110000,28'h123,Z,A5);
        vt[4]  = mk(1,0,32'h1230,Z,0,0,Z, 6'b101000,28'h123,Z,A5);
        vt[5]  = mk(0,0,32'h0,   Z,0,0,Z, 6'b000000,28'h123,Z,A5);
        vt[6]  = mk(1,1,32'h2000,D1,0,0,Z,6'b000000,28'h123,Z,A5);
        vt[7]  = mk(1,1,32'h2000,D1,0,0,Z,6'b000111,28'h200,D1,A5);
        vt[8]  = mk(1,0,32'h3000,Z,0,0,Z, 6'b100011,28'h200,D1,A5);
        vt[9]  = mk(1,0,32'h3000,Z,1,0,Z, 6'b100011,28'h200,D1,A5);
        vt[10] = mk(1,0,32'h3000,Z,0,0,Z, 6'b000000,28'h123,Z,A5);
        vt[11] = mk(1,0,32'h3000,Z,1,0,Z, 6'b100010,28'h300,Z,A5);
        vt[12] = mk(1,0,32'h3000,Z,0,0,Z, 6'b100000,28'h300,Z,A5);
        vt[13] = mk(1,0,32'h3000,Z,0,1,BB,6'b100000,28'h300,Z,A5);
        vt[14] = mk(1,0,32'h3000,Z,0,0,Z, 6'b110000,28'h300,Z,BB);
        vt[15] = mk(1,0,32'h3000,Z,0,0,Z, 6'b101000,28'h300,Z,BB);
        vt[16] = mk(0,0,32'h0,   Z,0,0,Z, 6'b000000,28'h300,Z,BB);

        reset = 1'b0;
        drive(0,0,32'h0,Z,0,0,Z);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 128'(outs()), 128'(0));
        chk("reset_data", data_wd_l2, Z);
        chk("reset_raddr", 128'(l2_req_addr), 128'(0));
        @(negedge clk);
        reset = 1'b1;

        // refill on empty wbuf, then victim write followed by refill
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].drq, vt[i].rw, vt[i].addr, vt[i].wd,
                  vt[i].gnt, vt[i].rv, vt[i].rd);
            #1;
            n_vec++;
            if (outs() !== vt[i].o || l2_req_addr !== vt[i].ra ||
                data_wd_l2 !== vt[i].dwd ||
                (vt[i].o[0] && l2_wdata !== vt[i].wdat)) begin
                n_bad++;
                $display("FAIL vec%0d out=%b/%b addr=%h/%h dwd=%h/%h",
                         i, outs(), vt[i].o, l2_req_addr, vt[i].ra,
                         data_wd_l2, vt[i].dwd);
            end
            @(negedge clk);
        end

        // wbuf full: third write waits for a freed slot
        drive(1,1,32'h5000,E1,0,0,Z); #1;
        chk("full_w1_busy", 128'(l2_busy), 128'(0));
        @(negedge clk); #1;
        chk("full_w1_cmp", 128'(outs()), 128'(6'b000111));
        chk("full_w1_addr", 128'(l2_req_addr), 128'(28'h500));
        @(negedge clk);
        drive(1,1,32'h6000,E2,0,0,Z); #1;
        chk("full_w2_acc", 128'(outs()), 128'(6'b000011));
        @(negedge clk); #1;
        chk("full_w2_cmp", 128'(outs()), 128'(6'b100111));
        @(negedge clk);
        drive(1,1,32'h7000,E3,0,0,Z); #1;
        chk("full_w3_busy", 128'(outs()), 128'(6'b100011));
        chk("full_head", l2_wdata, E1);
        repeat (2) begin
            @(negedge clk); #1;
            chk("full_w3_hold", 128'(outs()), 128'(6'b100011));
        end
        @(negedge clk);
        l2_gnt = 1'b1; #1;
        chk("full_gnt_busy", 128'(l2_busy), 128'(1));
        @(negedge clk);
        l2_gnt = 1'b0; #1;
        chk("full_w3_acc", 128'(outs()), 128'(6'b000011));
        chk("full_head2", 128'(l2_req_addr), 128'(28'h600));
        @(negedge clk); #1;
        chk("full_w3_cmp", 128'(outs()), 128'(6'b100111));
        @(negedge clk);
        drive(0,0,32'h0,Z,1,0,Z); #1;
        chk("drain_e2", l2_wdata, E2);
        @(negedge clk); #1;
        chk("drain_e3", l2_wdata, E3);
        chk("drain_e3a", 128'(l2_req_addr), 128'(28'h700));
        @(negedge clk);
        l2_gnt = 1'b0; #1;
        chk("drain_empty", 128'(outs()), 128'(0));

        // reset while waiting for read data
        @(negedge clk);
        drive(1,0,32'h8000,Z,0,0,Z); #1;
        chk("rst_rd_go", 128'(l2_busy), 128'(0));
        @(negedge clk);
        l2_gnt = 1'b1; #1;
        chk("rst_rd_req", 128'(l2_req_addr), 128'(28'h800));
        @(negedge clk);
        l2_gnt = 1'b0; reset = 1'b0; #1;
        chk("rst_rd_wait", 128'(outs()), 128'(6'b100000));
        @(negedge clk);
        reset = 1'b1;
        drive(0,0,32'h0,Z,0,1,CC); #1;
        chk("rst_outs", 128'(outs()), 128'(0));
        chk("rst_data", data_wd_l2, Z);
        chk("rst_addr", 128'(l2_req_addr), 128'(0));
        @(negedge clk);
        l2_rvalid = 1'b0; #1;
        chk("rst_late_rv", 128'(outs()), 128'(0));
        chk("rst_late_data", data_wd_l2, Z);

        // reset discards a buffered victim
        @(negedge clk);
        drive(1,1,32'hA000,E1,0,0,Z);
        @(negedge clk); #1;
        chk("rstw_cmp", 128'(outs()), 128'(6'b000111));
        @(negedge clk);
        drive(0,0,32'h0,Z,0,0,Z); reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; #1;
        chk("rstw_empty", 128'(outs()), 128'(0));

        // flush: drq dropped while the read is requesting
        @(negedge clk);
        drive(1,0,32'hB000,Z,0,0,Z); #1;
        chk("fl_go", 128'(l2_busy), 128'(0));
        @(negedge clk);
        drq = 1'b0; #1;
        chk("fl_req", 128'(outs()), 128'(6'b100010));
        chk("fl_addr", 128'(l2_req_addr), 128'(28'hB00));
        @(negedge clk);
        l2_gnt = 1'b1; #1;
        chk("fl_req2", 128'(outs()), 128'(6'b100010));
        @(negedge clk);
        drive(0,0,32'h0,Z,0,1,FF); #1;
        chk("fl_wait", 128'(outs()), 128'(6'b100000));
        @(negedge clk);
        l2_rvalid = 1'b0; #1;
        chk("fl_rdy", 128'(outs()), 128'(6'b110000));
        chk("fl_data", data_wd_l2, FF);
        n_cmp  = 0;
        n_rreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (complete) n_cmp++;
            if (l2_req && !l2_we) n_rreq++;
        end
        chk("fl_cmp_once", 128'(n_cmp), 128'(1));
        chk("fl_no_rereq", 128'(n_rreq), 128'(0));

`ifdef DCACHE_WBUF_FWD_EN
        // forwarding: read hits the buffered victim
        @(negedge clk);
        drive(1,1,32'h4000,E2,0,0,Z);
        @(negedge clk); #1;
        chk("fw_wcmp", 128'(l2_complete), 128'(1));
        @(negedge clk);
        drive(1,0,32'h4008,Z,0,0,Z); #1;
        chk("fw_busy", 128'(l2_busy), 128'(0));
        n_rreq = 0;
        @(negedge clk); #1;
        chk("fw_rdy", 128'(l2_rdy), 128'(1));
        chk("fw_data", data_wd_l2, E2);
        if (l2_req && !l2_we) n_rreq++;
        @(negedge clk); #1;
        chk("fw_cmp", 128'(complete), 128'(1));
        if (l2_req && !l2_we) n_rreq++;
        chk("fw_no_rd", 128'(n_rreq), 128'(0));
        @(negedge clk);
        drive(0,0,32'h0,Z,1,0,Z);
        @(negedge clk);
        l2_gnt = 1'b0; #1;
        chk("fw_drained", 128'(l2_req), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
